// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types for the branch update scheduler
package bp_pkg;

    localparam int BP_ADDR_WIDTH = 17;

    typedef struct packed {
        logic [BP_ADDR_WIDTH-1:0] address;
        logic                     take;
        logic                     mispredict;
    } branch_rec_t;

endpackage

// File: rtl/branch_update_scheduler_if.sv
// rtl/branch_update_scheduler_if.sv - commit ports, hold and predictor record bundle
interface branch_update_scheduler_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  in0_valid;
    logic                  in0_ready;
    logic [ADDR_WIDTH-1:0] in0_address;
    logic                  in0_take;
    logic                  in0_mispredict;
    logic                  in1_valid;
    logic                  in1_ready;
    logic [ADDR_WIDTH-1:0] in1_address;
    logic                  in1_take;
    logic                  in1_mispredict;
    logic                  hold;
    logic                  record_en;
    logic [ADDR_WIDTH-1:0] record_address;
    logic                  record_take;
    logic                  empty;

    modport master (
        output in0_valid, in0_address, in0_take, in0_mispredict,
        output in1_valid, in1_address, in1_take, in1_mispredict,
        output hold,
        input  in0_ready, in1_ready,
        input  record_en, record_address, record_take, empty
    );

    modport slave (
        input  in0_valid, in0_address, in0_take, in0_mispredict,
        input  in1_valid, in1_address, in1_take, in1_mispredict,
        input  hold,
        output in0_ready, in1_ready,
        output record_en, record_address, record_take, empty
    );

endinterface

// File: rtl/branch_rec_fifo.sv
// rtl/branch_rec_fifo.sv - dual-enqueue, single-dequeue circular record buffer
module branch_rec_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  branch_rec_t   wr0_rec,
    input  logic          wr1_en,
    input  branch_rec_t   wr1_rec,
    input  logic          rd_en,
    output branch_rec_t   head_rec,
    output logic [CW-1:0] count
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr0_idx, wr1_idx;
    branch_rec_t   mem [DEPTH];

    always_comb begin
        wr0_idx = tail_q;
        // Port 1 lands behind port 0 only when port 0 was also written.
        wr1_idx = wr0_en ? tail_q + PW'(1) : tail_q;
        tail_d  = tail_q + PW'(wr0_en) + PW'(wr1_en);
        head_d  = head_q + PW'(rd_en);
        count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_idx] <= wr0_rec;
        if (wr1_en) mem[wr1_idx] <= wr1_rec;
    end

    assign head_rec = mem[head_q];
    assign count    = count_q;

endmodule

// File: rtl/branch_update_scheduler.sv
// rtl/branch_update_scheduler.sv - orders two commit ports into one predictor update stream
// Optional BRANCH_STAT_EN adds saturating drained-branch and mispredict counters.
module branch_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    branch_update_scheduler_if.slave bus
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          in0_ready, in1_ready;
    logic          acc0, acc1;
    logic          record_en;
    branch_rec_t   wr0_rec, wr1_rec, head_rec;

    // Free space uses the registered count only; a same-cycle drain is not credited.
    always_comb begin
        free      = CW'(DEPTH) - count;
        in0_ready = (free >= CW'(1));
        in1_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !bus.in0_valid);
        acc0      = bus.in0_valid && in0_ready;
        acc1      = bus.in1_valid && in1_ready;
        record_en = (count != '0) && !bus.hold;
    end

    always_comb begin
        wr0_rec            = '0;
        wr0_rec.address    = BP_ADDR_WIDTH'(bus.in0_address);
        wr0_rec.take       = bus.in0_take;
        wr0_rec.mispredict = bus.in0_mispredict;
        wr1_rec            = '0;
        wr1_rec.address    = BP_ADDR_WIDTH'(bus.in1_address);
        wr1_rec.take       = bus.in1_take;
        wr1_rec.mispredict = bus.in1_mispredict;
    end

    branch_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (acc0),
        .wr0_rec  (wr0_rec),
        .wr1_en   (acc1),
        .wr1_rec  (wr1_rec),
        .rd_en    (record_en),
        .head_rec (head_rec),
        .count    (count)
    );

    assign bus.in0_ready      = in0_ready;
    assign bus.in1_ready      = in1_ready;
    assign bus.record_en      = record_en;
    assign bus.record_address = (count != '0) ? ADDR_WIDTH'(head_rec.address) : '0;
    assign bus.record_take    = (count != '0) ? head_rec.take : 1'b0;
    assign bus.empty          = (count == '0);

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (record_en && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (record_en && head_rec.mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = head_rec.mispredict;
`endif

endmodule

// File: tb/tb_branch_update_scheduler.sv
// tb/tb_branch_update_scheduler.sv - directed self-checking bench for branch_update_scheduler
module tb_branch_update_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    branch_update_scheduler_if #(.ADDR_WIDTH(17)) bus ();

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_update_scheduler #(
        .DEPTH      (8),
        .ADDR_WIDTH (17)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef BRANCH_STAT_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v0, input logic [16:0] a0, input logic t0, input logic m0,
                          input logic v1, input logic [16:0] a1, input logic t1, input logic m1);
        bus.in0_valid      = v0;
        bus.in0_address    = a0;
        bus.in0_take       = t0;
        bus.in0_mispredict = m0;
        bus.in1_valid      = v1;
        bus.in1_address    = a1;
        bus.in1_take       = t1;
        bus.in1_mispredict = m1;
    endtask

    task automatic idle();
        set_in(1'b0, 17'h0, 1'b0, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        bus.hold = 1'b0;

        // Reset state
        #2;
        check("rst_record_en", 32'(bus.record_en), 32'd0);
        check("rst_empty",     32'(bus.empty),     32'd1);
        check("rst_in0_ready", 32'(bus.in0_ready), 32'd1);
        check("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single record on port 0
        set_in(1'b1, 17'h00100, 1'b1, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
        @(negedge clk); idle(); #1;
        check("single_en",   32'(bus.record_en),      32'd1);
        check("single_addr", 32'(bus.record_address), 32'h00100);
        check("single_take", 32'(bus.record_take),    32'd1);
        @(negedge clk); #1;
        check("single_empty", 32'(bus.empty),     32'd1);
        check("single_en0",   32'(bus.record_en), 32'd0);

        // Both ports in one cycle drain in order
        set_in(1'b1, 17'h10, 1'b0, 1'b0, 1'b1, 17'h20, 1'b1, 1'b0);
        @(negedge clk); idle(); #1;
        check("pair_addr0", 32'(bus.record_address), 32'h10);
        check("pair_take0", 32'(bus.record_take),    32'd0);
        @(negedge clk); #1;
        check("pair_addr1", 32'(bus.record_address), 32'h20);
        check("pair_take1", 32'(bus.record_take),    32'd1);
        @(negedge clk); #1;
        check("pair_empty", 32'(bus.empty), 32'd1);

        // Fill under hold, then release
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 17'(16'h40 + 2*i), 1'b0, 1'b0, 1'b1, 17'(16'h41 + 2*i), 1'b1, 1'b0);
            #1;
            check("fill_in1_ready", 32'(bus.in1_ready), 32'd1);
            @(negedge clk);
        end
        set_in(1'b1, 17'h4F, 1'b1, 1'b0, 1'b1, 17'h4E, 1'b1, 1'b0);
        #1;
        check("full_in0_ready", 32'(bus.in0_ready), 32'd0);
        check("full_in1_ready", 32'(bus.in1_ready), 32'd0);
        check("full_record_en", 32'(bus.record_en), 32'd0);
        @(negedge clk);
        idle();
        bus.hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("full_drain_en",   32'(bus.record_en),      32'd1);
            check("full_drain_addr", 32'(bus.record_address), 32'h40 + 32'(i));
            check("full_drain_take", 32'(bus.record_take),    32'(i % 2));
            @(negedge clk);
        end
        #1;
        check("after_full_in0_ready", 32'(bus.in0_ready), 32'd1);
        check("after_full_in1_ready", 32'(bus.in1_ready), 32'd1);
        check("after_full_empty",     32'(bus.empty),     32'd1);

        // Seven entries, both ports valid: only port 0 accepted
        @(negedge clk);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 17'(16'h60 + 2*i), 1'b0, 1'b0, 1'b1, 17'(16'h61 + 2*i), 1'b0, 1'b0);
            @(negedge clk);
        end
        set_in(1'b1, 17'h66, 1'b0, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 17'h67, 1'b0, 1'b0, 1'b1, 17'h68, 1'b0, 1'b0);
        #1;
        check("c7_in0_ready", 32'(bus.in0_ready), 32'd1);
        check("c7_in1_ready", 32'(bus.in1_ready), 32'd0);
        @(negedge clk);
        set_in(1'b0, 17'h0, 1'b0, 1'b0, 1'b1, 17'h68, 1'b0, 1'b0);
        bus.hold = 1'b0;
        #1;
        check("c8_in1_ready", 32'(bus.in1_ready),      32'd0);
        check("c8_addr",      32'(bus.record_address), 32'h60);
        @(negedge clk); #1;
        check("retry_in1_ready", 32'(bus.in1_ready),      32'd1);
        check("retry_addr",      32'(bus.record_address), 32'h61);
        @(negedge clk);
        idle();
        for (int i = 2; i < 9; i++) begin
            #1;
            check("c7_drain_en",   32'(bus.record_en),      32'd1);
            check("c7_drain_addr", 32'(bus.record_address), 32'h60 + 32'(i));
            @(negedge clk);
        end
        #1;
        check("c7_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset with five queued entries
        @(negedge clk);
        bus.hold = 1'b1;
        set_in(1'b1, 17'h70, 1'b0, 1'b0, 1'b1, 17'h71, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 17'h72, 1'b0, 1'b0, 1'b1, 17'h73, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 17'h74, 1'b0, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        bus.hold = 1'b0;
        #1;
        check("pre_rst_en",   32'(bus.record_en),      32'd1);
        check("pre_rst_addr", 32'(bus.record_address), 32'h70);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_en",    32'(bus.record_en), 32'd0);
        check("async_rst_empty", 32'(bus.empty),     32'd1);
        check("async_rst_ready", 32'(bus.in1_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 17'h77, 1'b1, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("post_rst_en",   32'(bus.record_en),      32'd1);
        check("post_rst_addr", 32'(bus.record_address), 32'h77);
        @(negedge clk); #1;
        check("post_rst_empty", 32'(bus.empty), 32'd1);

        // Mispredict pattern 1,0,1
        @(negedge clk);
        rst = 1'b1;
        #1;
`ifdef BRANCH_STAT_EN
        check("stat_rst_br", stat_branches,    32'd0);
        check("stat_rst_mp", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.hold = 1'b1;
        set_in(1'b1, 17'h80, 1'b0, 1'b1, 1'b1, 17'h81, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 17'h82, 1'b1, 1'b1, 1'b0, 17'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        bus.hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stat_drain_empty", 32'(bus.empty), 32'd1);
`ifdef BRANCH_STAT_EN
        check("stat_branches",    stat_branches,    32'd3);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
